// File: rtl/fb_pkg.sv
// Shared types and constants for the double-buffered framebuffer controller.
package fb_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECV      = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  localparam logic [1:0] PH_R = 2'd0;
  localparam logic [1:0] PH_G = 2'd1;
  localparam logic [1:0] PH_B = 2'd2;

endpackage

// File: rtl/fb_bank_ram.sv
// Simple dual-port pixel RAM holding both banks; the bank bit is the address MSB.
module fb_bank_ram
  import fb_pkg::*;
#(
  parameter int aw = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  pixel_t        wdata,
  input  logic [aw-1:0] raddr,
  output pixel_t        rdata
);

  pixel_t mem [2**aw];
  pixel_t rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is reset; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fb_ctrl.sv
// Byte-stream to double-buffered framebuffer; banks swap only on a scan-address frame wrap.
module fb_ctrl
  import fb_pkg::*;
#(
  parameter  int length    = 32,
  parameter  int scan_bit  = 4,
  localparam int col_bits  = $clog2(length),
  localparam int addr_bits = scan_bit + col_bits
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  input  logic                 in_sof,
  output logic                 in_ready,
  input  logic [addr_bits-1:0] addr,
  output pixel_t               data1,
  output pixel_t               data2,
  output logic                 frame_swapped,
  output logic                 frame_abort
);

  localparam logic [col_bits-1:0] col_last = col_bits'(length - 1);
  localparam logic [scan_bit-1:0] row_last = {scan_bit{1'b1}};

  state_t               state_q, state_d;
  logic                 front_q, front_d;
  logic                 ready_q, ready_d;
  logic [1:0]           phase_q, phase_d;
  logic [7:0]           r_q, r_d, g_q, g_d;
  logic                 half_q, half_d;
  logic [scan_bit-1:0]  row_q, row_d;
  logic [col_bits-1:0]  col_q, col_d;
  logic [addr_bits-1:0] addr_q;

  logic   acc, swap_now, last_pix, we;
  pixel_t wpix;

  assign acc      = in_valid && ready_q;
  assign swap_now = (state_q == WAIT_SWAP) && (addr == '0) && (addr_q != '0);
  assign last_pix = half_q && (row_q == row_last) && (col_q == col_last);
  assign wpix     = {r_q, g_q, in_data};

  always_comb begin
    state_d       = state_q;
    front_d       = front_q;
    phase_d       = phase_q;
    r_d           = r_q;
    g_d           = g_q;
    half_d        = half_q;
    row_d         = row_q;
    col_d         = col_q;
    we            = 1'b0;
    frame_swapped = 1'b0;
    frame_abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc && in_sof) begin
          r_d     = in_data;
          phase_d = PH_G;
          half_d  = 1'b0;
          row_d   = '0;
          col_d   = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (acc && in_sof) begin
          // Restart the frame; the back bank keeps whatever was already written.
          frame_abort = 1'b1;
          r_d         = in_data;
          phase_d     = PH_G;
          half_d      = 1'b0;
          row_d       = '0;
          col_d       = '0;
        end else if (acc) begin
          case (phase_q)
            PH_R: begin
              r_d     = in_data;
              phase_d = PH_G;
            end
            PH_G: begin
              g_d     = in_data;
              phase_d = PH_B;
            end
            default: begin
              we      = 1'b1;
              phase_d = PH_R;
              if (col_q == col_last) begin
                col_d = '0;
                if (row_q == row_last) begin
                  row_d  = '0;
                  half_d = ~half_q;
                end else begin
                  row_d = row_q + 1'b1;
                end
              end else begin
                col_d = col_q + 1'b1;
              end
              if (last_pix) state_d = WAIT_SWAP;
            end
          endcase
        end
      end
      WAIT_SWAP: begin
        if (swap_now) begin
          front_d       = ~front_q;
          frame_swapped = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != WAIT_SWAP);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      front_q <= 1'b0;
      ready_q <= 1'b0;
      phase_q <= PH_R;
      r_q     <= '0;
      g_q     <= '0;
      half_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      ready_q <= ready_d;
      phase_q <= phase_d;
      r_q     <= r_d;
      g_q     <= g_d;
      half_q  <= half_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr;
    end
  end

  assign in_ready = ready_q;

  logic [addr_bits:0] waddr, raddr;
  assign waddr = {~front_q, row_q, col_q};
  // On the wrap cycle the read already targets the bank that becomes front.
  assign raddr = {front_q ^ swap_now, addr};

  fb_bank_ram #(.aw(addr_bits + 1)) u_upper (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we && !half_q),
    .waddr   (waddr),
    .wdata   (wpix),
    .raddr   (raddr),
    .rdata   (data1)
  );

  fb_bank_ram #(.aw(addr_bits + 1)) u_lower (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we && half_q),
    .waddr   (waddr),
    .wdata   (wpix),
    .raddr   (raddr),
    .rdata   (data2)
  );

endmodule

// File: doc/fb_ctrl.md
# fb_ctrl

Double-buffered framebuffer controller between the UART byte receiver and the `matrix` scan driver. Accepts a byte stream of RGB pixels, assembles 24-bit pixels into the back bank and serves the front bank to `matrix` through its `addr`/`data1`/`data2` read interface. Banks swap only at a frame wrap of the scan address, so the display never tears.

## Interface

Parameters:
- `length`, 32, pixels per row (columns); need not be a power of two
- `scan_bit`, 4, row-select bits; rows per half = 2**scan_bit

Derived:
- `col_bits` = $clog2(length)
- `addr_bits` = scan_bit + col_bits

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  synchronous, active-low reset
- `in_data`  in  8  received byte
- `in_valid`  in  1  byte valid
- `in_sof`  in  1  qualifies `in_data` as first byte (R of pixel 0) of a frame
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`
- `addr`  in  addr_bits  scan address from `matrix`, packed {row, col}
- `data1`  out  24  upper-half pixel at `addr`, {R,G,B}
- `data2`  out  24  lower-half pixel at `addr`
- `frame_swapped`  out  1  one-cycle pulse when the banks swap
- `frame_abort`  out  1  one-cycle pulse when a partial frame is discarded

## Operation

- Frame layout: 2·rows·length pixels, 3 bytes each (R, G, B; R lands in [23:16]).
- Pixel index p < rows·length goes to the upper half; the rest go to the lower half. Within a half, pixels are row-major. Write address is {row, col}; col wraps at length-1, and codes ≥ length are never written.
- FSM:
  - IDLE: `in_ready`=1. Bytes without `in_sof` are dropped. An accepted byte with `in_sof` is taken as R of pixel 0, byte phase→1, then → RECV.
  - RECV: `in_ready`=1. Byte phase counts 0,1,2. On phase-2 acceptance, the assembled pixel is written to the back bank at the current {half,row,col} on the same edge and the pointer advances. The write of the last pixel (half 1, row rows-1, col length-1) → WAIT_SWAP.
  - RECV, accepted byte with `in_sof`: pulse `frame_abort`, reset the pointer, take the byte as R of pixel 0, stay in RECV. The back bank keeps stale data from the aborted frame.
  - WAIT_SWAP: `in_ready`=0. On frame wrap: flip `front`, pulse `frame_swapped`, → IDLE.
- Frame wrap: `addr`==0 while registered `addr_q`≠0.
- Reads use the bank `front ^ swap_now`, so the addr-0 read on the wrap cycle already returns the new frame.
- Memory contents are not cleared by reset.

## Timing

- Reset values: `in_ready`=0, `data1`=`data2`=0, `frame_swapped`=`frame_abort`=0, state IDLE, `front`=0, `addr_q`=0, pointer and byte phase 0.
- `in_ready` is 1 on the first cycle after `reset_n` goes high.
- Read latency is 1 cycle: `data1`/`data2` at t+1 = front[`addr` at t]. This is independent of write activity, because writes only touch the back bank.
- Write to memory on the same edge the third byte is accepted.
- WAIT_SWAP is entered on the edge after the last write. `in_ready` is 0 from the next cycle until the cycle after the swap edge.
- The first wrap after reset requires `addr` to have been nonzero at least once.
- Reset mid-frame discards the partial frame: no swap, and `front` returns to 0.

## Structure

- Package `fb_pkg`:
  - `pixel_t` (logic [23:0])
  - `state_t` enum {IDLE, RECV, WAIT_SWAP}
  - byte-phase constants
- Sub-module `fb_bank_ram`: simple dual-port RAM.
  - One write port and one synchronous read port, width 24, depth 2**(addr_bits+1).
  - The bank bit is the address MSB.
  - Instantiated twice: upper half (feeds `data1`) and lower half (feeds `data2`).
- Top level holds the FSM, byte assembler, write pointer, `addr_q` and swap logic.

## Test plan

All scenarios use length=5, scan_bit=2 (4 rows, 20 pixels/half, 120 bytes/frame, addr_bits=5). The `matrix` model sweeps addr over {row,col}, col 0..4, rows 0..3, repeating.

1. Reset: hold `reset_n`=0 for 3 cycles → `in_ready`=0, `data1`=`data2`=0, no pulses. Release → `in_ready`=1 one cycle later.
2. Full frame: `in_sof` + 120 bytes, with pixel p = {p, ~p, p}. Then let addr wrap → `frame_swapped` pulses on the addr-0 cycle. Afterwards addr {1,2} gives `data1`=0x07F807 and `data2`=0x1BE41B.
3. Backpressure: after the last byte, hold `in_valid`=1 with `in_sof` → `in_ready`=0 until the swap, then the byte is accepted as the start of the next frame and no byte is lost.
4. Abort: `in_sof` + 10 bytes, then `in_sof` byte 0xAA → `frame_abort` pulse. After 120 bytes total from the new SOF, pixel 0 R = 0xAA.
5. Stray bytes: 5 bytes in IDLE without `in_sof`, then a valid frame → displayed frame matches the valid frame exactly.
6. Reset mid-frame: reset after 50 bytes, then a full frame, then a wrap → `front` ends at 1 and `frame_swapped` pulses exactly once.
